// File: rtl/pc_fetch_unit_if.sv
// ----------------------------------------------------------------------------
// pc_fetch_unit_if
// Bundles the PC interface (ROB redirect, dispatch consume, instruction
// presentation) and the instruction-cache request/response bus of the fetch
// front end.
//   master : the fetch unit (drives PC, instructions and cache requests)
//   slave  : the surrounding core (ROB, dispatch, instruction cache)
// Signals:
//   jump_address/wr      redirect target and strobe from the ROB
//   inc/inc2             dispatch consumed one / two instructions
//   address              PC of the oldest buffered instruction
//   instr0/instr1        two oldest buffered words
//   instr_valid          [0]=instr0 valid, [1]=instr1 valid
//   icache_req/addr      fetch request valid / aligned 8-byte address
//   icache_ready         cache accepts the request this cycle
//   icache_rvalid/rdata  response valid / two words {addr+4, addr}
// ----------------------------------------------------------------------------
interface pc_fetch_unit_if;
    logic [31:0] jump_address;
    logic        wr;
    logic        inc;
    logic        inc2;
    logic [31:0] address;
    logic [31:0] instr0;
    logic [31:0] instr1;
    logic [1:0]  instr_valid;
    logic        icache_req;
    logic [31:0] icache_addr;
    logic        icache_ready;
    logic        icache_rvalid;
    logic [63:0] icache_rdata;

    modport master (
        input  jump_address, wr, inc, inc2,
        input  icache_ready, icache_rvalid, icache_rdata,
        output address, instr0, instr1, instr_valid,
        output icache_req, icache_addr
    );

    modport slave (
        output jump_address, wr, inc, inc2,
        output icache_ready, icache_rvalid, icache_rdata,
        input  address, instr0, instr1, instr_valid,
        input  icache_req, icache_addr
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// ----------------------------------------------------------------------------
// pc_fetch_unit
// Program-counter owner and instruction-fetch front end. Issues aligned
// 8-byte fetches to the instruction cache, buffers returned words in a FIFO
// and presents the two oldest instructions to dispatch. The ROB redirects
// the PC; dispatch advances it.
// Ports:
//   clk           clock
//   reset         synchronous, active-low reset
//   bus           pc_fetch_unit_if.master (PC interface + icache bus)
//   stall_cycles  (only with FETCH_PERF_CNT_EN) saturating count of cycles
//                 with no valid instruction and no redirect
// Parameters:
//   RESET_VECTOR  start PC after reset (4-byte aligned)
//   DEPTH         FIFO entries in 32-bit words (power of two, >= 4)
// Optional feature macro: FETCH_PERF_CNT_EN
// ----------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          DEPTH        = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    pc_fetch_unit_if.master      bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]          stall_cycles
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // Architectural state
    logic [31:0]      pc_r;
    logic [31:0]      fetch_pc_r;
    logic [31:0]      mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             outstanding_r;
    logic             epoch_r;
    logic             tag_r;
    logic             req_odd_r;
    // Set when reset hit an unanswered request; the late response is eaten.
    logic             drop_r;

    // Combinational control
    logic [CNT_W-1:0] free_s;
    logic             req_s;
    logic             accept_s;
    logic             resp_ok_s;
    logic [1:0]       push_n_s;
    logic [1:0]       pop_n_s;
    logic [31:0]      push_w0_s;
    logic [31:0]      push_w1_s;
    logic [31:0]      jump_aligned_s;

    // Request issue, response acceptance and consume decode
    always_comb begin
        free_s         = DEPTH_C - count_r;
        jump_aligned_s = bus.jump_address & 32'hFFFF_FFFC;
        // reset gates the request so nothing is accepted while in reset
        req_s          = reset & ~outstanding_r & ~drop_r & ~bus.wr &
                         (free_s >= CNT_W'(2));
        accept_s       = req_s & bus.icache_ready;
        resp_ok_s      = bus.icache_rvalid & ~drop_r & ~bus.wr & (tag_r == epoch_r);

        push_n_s  = 2'd0;
        push_w0_s = bus.icache_rdata[31:0];
        push_w1_s = bus.icache_rdata[63:32];
        if (resp_ok_s) begin
            if (req_odd_r) begin
                // jump into the odd word: only the upper word is wanted
                push_n_s  = 2'd1;
                push_w0_s = bus.icache_rdata[63:32];
            end else begin
                push_n_s  = 2'd2;
            end
        end else begin
            push_n_s = 2'd0;
        end

        // inc2 wins over inc; a consume larger than the buffer is ignored
        pop_n_s = 2'd0;
        if (bus.wr) begin
            pop_n_s = 2'd0;
        end else if (bus.inc2) begin
            pop_n_s = (count_r >= CNT_W'(2)) ? 2'd2 : 2'd0;
        end else if (bus.inc) begin
            pop_n_s = (count_r >= CNT_W'(1)) ? 2'd1 : 2'd0;
        end else begin
            pop_n_s = 2'd0;
        end
    end

    // PC, fetch pointer, FIFO bookkeeping and request tracking
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_r          <= RESET_VECTOR;
            fetch_pc_r    <= RESET_VECTOR;
            rd_ptr_r      <= '0;
            wr_ptr_r      <= '0;
            count_r       <= '0;
            outstanding_r <= 1'b0;
            epoch_r       <= 1'b0;
            tag_r         <= 1'b0;
            req_odd_r     <= 1'b0;
            // remember an unanswered request unless its answer is here now
            drop_r        <= (outstanding_r | drop_r) & ~bus.icache_rvalid;
        end else begin
            if (bus.wr) begin
                pc_r       <= jump_aligned_s;
                fetch_pc_r <= jump_aligned_s;
                rd_ptr_r   <= '0;
                wr_ptr_r   <= '0;
                count_r    <= '0;
                epoch_r    <= ~epoch_r;
            end else begin
                pc_r     <= pc_r + 32'({pop_n_s, 2'b00});
                rd_ptr_r <= rd_ptr_r + PTR_W'(pop_n_s);
                wr_ptr_r <= wr_ptr_r + PTR_W'(push_n_s);
                count_r  <= count_r + CNT_W'(push_n_s) - CNT_W'(pop_n_s);
                if (accept_s) begin
                    fetch_pc_r <= (fetch_pc_r & 32'hFFFF_FFF8) + 32'd8;
                end else begin
                    fetch_pc_r <= fetch_pc_r;
                end
            end

            if (accept_s) begin
                outstanding_r <= 1'b1;
                tag_r         <= epoch_r;
                req_odd_r     <= fetch_pc_r[2];
            end else if (bus.icache_rvalid && !drop_r) begin
                outstanding_r <= 1'b0;
            end else begin
                outstanding_r <= outstanding_r;
            end

            if (bus.icache_rvalid) begin
                drop_r <= 1'b0;
            end else begin
                drop_r <= drop_r;
            end
        end
    end

    // FIFO storage write port (data only, no reset needed)
    always_ff @(posedge clk) begin
        if (push_n_s != 2'd0) begin
            mem_r[wr_ptr_r] <= push_w0_s;
        end
        if (push_n_s == 2'd2) begin
            mem_r[wr_ptr_r + PTR_W'(1)] <= push_w1_s;
        end
    end

    assign bus.address     = pc_r;
    assign bus.instr0      = mem_r[rd_ptr_r];
    assign bus.instr1      = mem_r[rd_ptr_r + PTR_W'(1)];
    assign bus.instr_valid = {(count_r >= CNT_W'(2)), (count_r >= CNT_W'(1))};
    assign bus.icache_req  = req_s;
    assign bus.icache_addr = fetch_pc_r & 32'hFFFF_FFF8;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_r;

    // Saturating count of cycles with an empty buffer and no redirect
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_r <= 32'd0;
        end else if ((count_r == '0) && !bus.wr && (stall_r != 32'hFFFF_FFFF)) begin
            stall_r <= stall_r + 32'd1;
        end else begin
            stall_r <= stall_r;
        end
    end

    assign stall_cycles = stall_r;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_pc_fetch_unit
// Directed bench: a small instruction-cache model answers each accepted
// request after a programmable latency with words word(a) = (a/4+1)*0x11.
// A table of consume vectors is applied to a full buffer, followed by
// hand-written redirect and reset-while-outstanding sequences.
// ----------------------------------------------------------------------------
module tb_pc_fetch_unit;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pc_fetch_unit_if bus_if();
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cycles;
`endif

    pc_fetch_unit #(.RESET_VECTOR(32'h0000_0000), .DEPTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.master)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // cache model state
    int          lat;
    logic        pend;
    int          cnt;
    logic [31:0] pend_addr;

    typedef struct {
        logic        inc;
        logic        inc2;
        logic [31:0] exp_addr;
        logic [1:0]  exp_valid;
        logic [31:0] exp_i0;
        logic [31:0] exp_i1;
        logic        exp_req;
    } vec_t;

    vec_t vecs[9];

    function automatic logic [31:0] word(input logic [31:0] a);
        return ((a >> 2) + 32'd1) * 32'h11;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // one clock: note handshake, cross the edge, advance the cache model
    task automatic tick();
        logic        acc;
        logic [31:0] a;
        #1;
        acc = bus_if.icache_req && bus_if.icache_ready;
        a   = bus_if.icache_addr;
        @(posedge clk);
        #1;
        bus_if.icache_rvalid = 1'b0;
        if (acc) begin
            pend      = 1'b1;
            cnt       = lat;
            pend_addr = a;
        end
        if (pend) begin
            cnt--;
            if (cnt == 0) begin
                bus_if.icache_rvalid = 1'b1;
                bus_if.icache_rdata  = {word(pend_addr + 32'd4), word(pend_addr)};
                pend = 1'b0;
            end
        end
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b1, 32'h08, 2'b11, 32'h33, 32'h44, 1'b1};
        vecs[1] = '{1'b1, 1'b0, 32'h0C, 2'b11, 32'h44, 32'h55, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 32'h14, 2'b11, 32'h66, 32'h77, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 32'h14, 2'b11, 32'h66, 32'h77, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 32'h18, 2'b11, 32'h77, 32'h88, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 32'h1C, 2'b01, 32'h88, 32'h00, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 32'h1C, 2'b01, 32'h88, 32'h00, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 32'h20, 2'b00, 32'h00, 32'h00, 1'b1};
        vecs[8] = '{1'b1, 1'b0, 32'h20, 2'b00, 32'h00, 32'h00, 1'b1};

        reset = 1'b0;
        bus_if.jump_address  = 32'h0;
        bus_if.wr            = 1'b0;
        bus_if.inc           = 1'b0;
        bus_if.inc2          = 1'b0;
        bus_if.icache_ready  = 1'b1;
        bus_if.icache_rvalid = 1'b0;
        bus_if.icache_rdata  = 64'h0;
        lat  = 2;
        pend = 1'b0;
        cnt  = 0;
        pend_addr = 32'h0;

        // ---- reset and first fetch ----
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("rst_address", bus_if.address, 32'h0);
        check("rst_valid", 32'(bus_if.instr_valid), 32'h0);
        check("first_req", 32'(bus_if.icache_req), 32'h1);
        check("first_req_addr", bus_if.icache_addr, 32'h0);
        tick();
        tick();
        tick();
        check("first_valid", 32'(bus_if.instr_valid), 32'h3);
        check("first_instr0", bus_if.instr0, 32'h11);
        check("first_instr1", bus_if.instr1, 32'h22);
        check("first_address", bus_if.address, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        check("stall_after_fill", stall_cycles, 32'd3);
`endif

        // ---- fill to DEPTH with no consumption ----
        for (int i = 0; i < 20; i++) tick();
        check("full_valid", 32'(bus_if.instr_valid), 32'h3);
        check("full_req_off", 32'(bus_if.icache_req), 32'h0);
        check("full_instr0", bus_if.instr0, 32'h11);
        check("full_instr1", bus_if.instr1, 32'h22);
        check("full_address", bus_if.address, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        check("stall_hold", stall_cycles, 32'd3);
`endif

        // ---- table-driven consume vectors on a full buffer, cache stalled ----
        bus_if.icache_ready = 1'b0;
        for (int v = 0; v < 9; v++) begin
            bus_if.inc  = vecs[v].inc;
            bus_if.inc2 = vecs[v].inc2;
            tick();
            bus_if.inc  = 1'b0;
            bus_if.inc2 = 1'b0;
            #1;
            check($sformatf("vec%0d_address", v), bus_if.address, vecs[v].exp_addr);
            check($sformatf("vec%0d_valid", v), 32'(bus_if.instr_valid), 32'(vecs[v].exp_valid));
            check($sformatf("vec%0d_req", v), 32'(bus_if.icache_req), 32'(vecs[v].exp_req));
            if (vecs[v].exp_valid[0]) check($sformatf("vec%0d_instr0", v), bus_if.instr0, vecs[v].exp_i0);
            if (vecs[v].exp_valid[1]) check($sformatf("vec%0d_instr1", v), bus_if.instr1, vecs[v].exp_i1);
            if (vecs[v].exp_req) check($sformatf("vec%0d_req_addr", v), bus_if.icache_addr, 32'h20);
        end

        // ---- redirect while a request is in flight ----
        lat = 3;
        bus_if.icache_ready = 1'b1;
        tick();                                   // request to 0x20 accepted
        bus_if.wr = 1'b1;
        bus_if.jump_address = 32'h0000_0106;      // low bits must be cleared
        #1;
        check("wr_req_forced_off", 32'(bus_if.icache_req), 32'h0);
        tick();
        bus_if.wr = 1'b0;
        bus_if.jump_address = 32'h0;
        #1;
        check("wr_address", bus_if.address, 32'h104);
        check("wr_flush_valid", 32'(bus_if.instr_valid), 32'h0);
        check("wr_wait_stale", 32'(bus_if.icache_req), 32'h0);
        tick();                                   // stale response on the bus
        tick();                                   // stale response dropped
        check("stale_dropped", 32'(bus_if.instr_valid), 32'h0);
        check("redir_req", 32'(bus_if.icache_req), 32'h1);
        check("redir_req_addr", bus_if.icache_addr, 32'h100);
        for (int i = 0; i < 4; i++) tick();
        check("redir_valid", 32'(bus_if.instr_valid), 32'h1);
        check("redir_address", bus_if.address, 32'h104);
        check("redir_instr0", bus_if.instr0, 32'h462);
        check("redir_next_addr", bus_if.icache_addr, 32'h108);

        // ---- reset pulsed while a request is outstanding ----
        lat = 4;
        tick();                                   // request to 0x108 accepted
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        check("rst2_address", bus_if.address, 32'h0);
        check("rst2_valid", 32'(bus_if.instr_valid), 32'h0);
        check("rst2_req_blocked", 32'(bus_if.icache_req), 32'h0);
        tick();
        tick();                                   // late response on the bus
        check("rst2_late_rvalid", 32'(bus_if.icache_rvalid), 32'h1);
        tick();                                   // late response discarded
        check("rst2_fifo_empty", 32'(bus_if.instr_valid), 32'h0);
        check("rst2_address_hold", bus_if.address, 32'h0);
        check("rst2_req_resume", 32'(bus_if.icache_req), 32'h1);
        check("rst2_req_addr", bus_if.icache_addr, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
